// File: rtl/dev_csr_pkg.sv
// Shared definitions for the device interrupt scheduler: CSR bit layout,
// scheduler state encoding and the per-device request decode.
package dev_csr_pkg;

    localparam int CSR_ENA = 4;
    localparam int CSR_OF  = 3;
    localparam int CSR_DBA = 2;
    localparam int CSR_IO  = 1;
    localparam int CSR_IE  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } irq_state_e;

    // A device requests service when enabled, interrupt-enabled and data-ready.
    function automatic logic csr_req(input logic [7:0] csr);
        return csr[CSR_ENA] & csr[CSR_IE] & csr[CSR_DBA];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin find-first: lowest request index at or after
// ptr_i, wrapping modulo N_DEV.
module rr_pick #(
    parameter int N_DEV = 4,
    parameter int PW    = 2
) (
    input  logic [N_DEV-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [PW-1:0]    grant_o,
    output logic             any_o
);

    // Scan from farthest to nearest so the nearest requester is written last.
    always_comb begin
        int idx;
        idx     = 0;
        grant_o = ptr_i;
        any_o   = |req_i;
        for (int k = N_DEV - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % N_DEV;
            if (req_i[idx]) begin
                grant_o = PW'(idx);
            end else begin
                grant_o = grant_o;
            end
        end
    end

endmodule

// File: rtl/dev_irq_sched.sv
// Round-robin interrupt scheduler over N_DEV character-device CSRs: raises one
// CPU interrupt at a time and sequences acknowledge, timeout and hold-off.
module dev_irq_sched
    import dev_csr_pkg::*;
#(
    parameter int N_DEV    = 4,
    parameter int VEC_BASE = 8,
    parameter int VEC_W    = 4,
    parameter int TIMEOUT  = 255,
    parameter int HOLDOFF  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic [8*N_DEV-1:0]   csr_i,
    input  logic                 ack_i,
    output logic                 irq_o,
    output logic [VEC_W-1:0]     vec_o,
    output logic [N_DEV-1:0]     svc_o,
    output logic [N_DEV-1:0]     tmo_o,
    output logic [N_DEV-1:0]     ovf_o,
    input  logic [N_DEV-1:0]     tmo_clr_i
);

    localparam int              PW        = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam int              CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   CNT_MAX   = CW'(TIMEOUT);
    localparam logic [3:0]      HOLD_LAST = (HOLDOFF > 0) ? 4'(HOLDOFF - 1) : 4'd0;
    localparam logic [PW-1:0]   LAST_DEV  = PW'(N_DEV - 1);
    localparam logic [N_DEV-1:0] DEV0_OH  = {{(N_DEV-1){1'b0}}, 1'b1};

    irq_state_e         state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      g_q, g_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         hcnt_q, hcnt_d;
    logic               irq_q, irq_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [N_DEV-1:0]   svc_q, svc_d;
    logic [N_DEV-1:0]   tmo_q, tmo_d;
    logic [N_DEV-1:0]   ovf_q, ovf_d;
    logic [N_DEV-1:0]   of_q, of_d;

    logic [N_DEV-1:0]   req_s;
    logic [N_DEV-1:0]   of_s;
    logic [N_DEV-1:0]   tmo_set_s;
    logic [PW-1:0]      grant_s;
    logic [PW-1:0]      ptr_nxt_s;
    logic               any_s;
    logic               unused_csr_s;

    assign unused_csr_s = ^csr_i;

    // Per-device request and overflow bits decoded from the packed CSRs.
    always_comb begin
        req_s = {N_DEV{1'b0}};
        of_s  = {N_DEV{1'b0}};
        for (int i = 0; i < N_DEV; i++) begin
            req_s[i] = csr_req(csr_i[8*i +: 8]);
            of_s[i]  = csr_i[8*i + CSR_OF];
        end
    end

    rr_pick #(
        .N_DEV (N_DEV),
        .PW    (PW)
    ) u_rr_pick (
        .req_i   (req_s),
        .ptr_i   (ptr_q),
        .grant_o (grant_s),
        .any_o   (any_s)
    );

    // Scheduler next-state: ack beats timeout beats withdraw beats enable drop.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        g_d       = g_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        irq_d     = irq_q;
        vec_d     = vec_q;
        svc_d     = {N_DEV{1'b0}};
        tmo_set_s = {N_DEV{1'b0}};
        ptr_nxt_s = (g_q == LAST_DEV) ? {PW{1'b0}} : g_q + PW'(1);
        case (state_q)
            IDLE: begin
                if (en_i && any_s) begin
                    g_d     = grant_s;
                    vec_d   = VEC_W'(VEC_BASE + int'(grant_s));
                    irq_d   = 1'b1;
                    cnt_d   = {CW{1'b0}};
                    state_d = REQ;
                end else begin
                    irq_d   = 1'b0;
                end
            end
            REQ: begin
                if (ack_i) begin
                    svc_d   = DEV0_OH << g_q;
                    irq_d   = 1'b0;
                    ptr_d   = ptr_nxt_s;
                    hcnt_d  = 4'd0;
                    state_d = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_set_s = DEV0_OH << g_q;
                    irq_d     = 1'b0;
                    ptr_d     = ptr_nxt_s;
                    hcnt_d    = 4'd0;
                    state_d   = HOLD;
                end else if (!req_s[g_q] || !en_i) begin
                    irq_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = (cnt_q < CNT_MAX) ? cnt_q + CW'(1) : cnt_q;
                end
            end
            HOLD: begin
                irq_d = 1'b0;
                if (hcnt_q >= HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    hcnt_d  = hcnt_q + 4'd1;
                end
            end
            default: begin
                irq_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Sticky flags: a set in the same cycle as a clear is kept.
    always_comb begin
        tmo_d = (tmo_q & ~tmo_clr_i) | tmo_set_s;
        ovf_d = (ovf_q & ~tmo_clr_i) | (of_s & ~of_q);
        of_d  = of_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= {PW{1'b0}};
            g_q     <= {PW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            hcnt_q  <= 4'd0;
            irq_q   <= 1'b0;
            vec_q   <= {VEC_W{1'b0}};
            svc_q   <= {N_DEV{1'b0}};
            tmo_q   <= {N_DEV{1'b0}};
            ovf_q   <= {N_DEV{1'b0}};
            of_q    <= {N_DEV{1'b0}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
            svc_q   <= svc_d;
            tmo_q   <= tmo_d;
            ovf_q   <= ovf_d;
            of_q    <= of_d;
        end
    end

    assign irq_o = irq_q;
    assign vec_o = vec_q;
    assign svc_o = svc_q;
    assign tmo_o = tmo_q;
    assign ovf_o = ovf_q;

endmodule

// File: tb/tb_dev_irq_sched.sv
// Directed bench for dev_irq_sched: a cycle-level service model checked on
// every cycle, plus hand-computed literal expectations per scenario.
module tb_dev_irq_sched;

    localparam int N_DEV    = 4;
    localparam int VEC_BASE = 8;
    localparam int VEC_W    = 4;
    localparam int TIMEOUT  = 16;
    localparam int HOLDOFF  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en_i;
    logic [8*N_DEV-1:0]   csr_i;
    logic                 ack_i;
    logic [N_DEV-1:0]     tmo_clr_i;
    logic                 irq_o;
    logic [VEC_W-1:0]     vec_o;
    logic [N_DEV-1:0]     svc_o;
    logic [N_DEV-1:0]     tmo_o;
    logic [N_DEV-1:0]     ovf_o;

    int errors = 0;
    int checks = 0;

    dev_irq_sched #(
        .N_DEV    (N_DEV),
        .VEC_BASE (VEC_BASE),
        .VEC_W    (VEC_W),
        .TIMEOUT  (TIMEOUT),
        .HOLDOFF  (HOLDOFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en_i),
        .csr_i     (csr_i),
        .ack_i     (ack_i),
        .irq_o     (irq_o),
        .vec_o     (vec_o),
        .svc_o     (svc_o),
        .tmo_o     (tmo_o),
        .ovf_o     (ovf_o),
        .tmo_clr_i (tmo_clr_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Service model: which device is being served, for how long, and how much
    // idle gap remains; outputs follow directly from those facts.
    bit m_on = 1'b0;
    bit m_irq = 1'b0;
    int m_g = 0, m_age = 0, m_hold = 0, m_ptr = 0, m_vec = 0;
    int m_svc = 0, m_tmo = 0, m_ovf = 0, m_of_prev = 0;

    always @(posedge clk) begin
        int req, ofb, g;
        req = 0;
        ofb = 0;
        for (int i = 0; i < N_DEV; i++) begin
            if (csr_i[8*i+4] && csr_i[8*i+2] && csr_i[8*i+0]) req = req | (1 << i);
            if (csr_i[8*i+3]) ofb = ofb | (1 << i);
        end
        if (rst) begin
            m_on = 1'b1; m_irq = 1'b0; m_g = 0; m_age = 0; m_hold = 0; m_ptr = 0;
            m_vec = 0; m_svc = 0; m_tmo = 0; m_ovf = 0; m_of_prev = 0;
        end else begin
            m_ovf = (m_ovf & ~int'(tmo_clr_i)) | (ofb & ~m_of_prev);
            m_tmo = m_tmo & ~int'(tmo_clr_i);
            m_svc = 0;
            if (m_irq) begin
                if (ack_i) begin
                    m_svc = 1 << m_g; m_irq = 1'b0;
                    m_ptr = (m_g + 1) % N_DEV; m_hold = (HOLDOFF > 0) ? HOLDOFF : 1;
                end else if (m_age == TIMEOUT) begin
                    m_tmo = m_tmo | (1 << m_g); m_irq = 1'b0;
                    m_ptr = (m_g + 1) % N_DEV; m_hold = (HOLDOFF > 0) ? HOLDOFF : 1;
                end else if (!req[m_g] || !en_i) begin
                    m_irq = 1'b0;
                end else begin
                    m_age++;
                end
            end else if (m_hold > 0) begin
                m_hold--;
            end else if (en_i && req != 0) begin
                g = m_ptr;
                while (!req[g]) g = (g + 1) % N_DEV;
                m_g = g; m_vec = (VEC_BASE + g) % (1 << VEC_W);
                m_irq = 1'b1; m_age = 1;
            end
            m_of_prev = ofb;
        end
    end

    // Compare every cycle on the falling edge once the model has seen reset.
    always @(negedge clk) begin
        if (m_on) begin
            check("irq_model", irq_o, 32'(m_irq));
            check("svc_model", svc_o, m_svc);
            check("tmo_model", tmo_o, m_tmo);
            check("ovf_model", ovf_o, m_ovf);
            if (m_irq) check("vec_model", vec_o, m_vec);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_irq(input string name);
        int k;
        k = 0;
        while (irq_o !== 1'b1 && k < 40) begin
            cyc(1);
            k++;
        end
        check(name, irq_o, 1);
    endtask

    int fair_vec [4] = '{8, 10, 8, 10};
    int hi_cnt;

    initial begin
        rst = 1'b1; en_i = 1'b0; csr_i = '0; ack_i = 1'b0; tmo_clr_i = '0;
        cyc(3);
        check("rst_irq", irq_o, 0);
        check("rst_vec", vec_o, 0);
        check("rst_svc", svc_o, 0);
        check("rst_tmo", tmo_o, 0);
        check("rst_ovf", ovf_o, 0);
        rst = 1'b0;
        cyc(1);

        // Single request on dev1
        en_i = 1'b1; csr_i = 32'h0000_1500;
        cyc(1);
        check("single_irq", irq_o, 1);
        check("single_vec", vec_o, 9);
        ack_i = 1'b1;
        cyc(1);
        ack_i = 1'b0;
        check("single_svc", svc_o, 4'b0010);
        check("single_irq_drop", irq_o, 0);
        cyc(2);
        check("holdoff_gap", irq_o, 0);
        cyc(1);
        check("rearb_irq", irq_o, 1);
        csr_i = '0;
        cyc(3);

        // Fairness between dev0 and dev2
        rst = 1'b1; cyc(1); rst = 1'b0;
        csr_i = 32'h0015_0015;
        for (int n = 0; n < 4; n++) begin
            wait_irq("fair_rise");
            check("fair_vec", vec_o, fair_vec[n]);
            cyc(2);
            ack_i = 1'b1;
            cyc(1);
            ack_i = 1'b0;
        end
        csr_i = '0;
        cyc(4);

        // Timeout on dev3
        csr_i = 32'h1500_0000;
        wait_irq("tmo_rise");
        check("tmo_vec", vec_o, 11);
        hi_cnt = 0;
        while (irq_o === 1'b1 && hi_cnt < 40) begin
            hi_cnt++;
            cyc(1);
        end
        csr_i = '0;
        check("tmo_irq_len", hi_cnt, TIMEOUT);
        check("tmo_flag", tmo_o, 4'b1000);
        tmo_clr_i = 4'b1000;
        cyc(1);
        tmo_clr_i = '0;
        check("tmo_clr", tmo_o, 0);
        cyc(3);

        // Withdraw before ack: irq drops, late ack ignored, pointer kept at dev0
        csr_i = 32'h0000_0015;
        wait_irq("wd_rise");
        check("wd_vec", vec_o, 8);
        csr_i = 32'h0000_0011;
        cyc(1);
        check("wd_irq_drop", irq_o, 0);
        ack_i = 1'b1;
        cyc(1);
        ack_i = 1'b0;
        check("wd_no_svc", svc_o, 0);
        cyc(2);
        csr_i = 32'h0000_1515;
        wait_irq("ptr_rise");
        check("ptr_kept_vec", vec_o, 8);
        // Withdraw in the same cycle as ack: ack wins
        csr_i = 32'h0000_1511; ack_i = 1'b1;
        cyc(1);
        ack_i = 1'b0;
        check("ack_beats_wd", svc_o, 4'b0001);
        csr_i = '0;
        cyc(4);

        // Global enable gating
        en_i = 1'b0; csr_i = 32'h0015_0000;
        cyc(4);
        check("gate_irq", irq_o, 0);
        en_i = 1'b1;
        wait_irq("gate_rise");
        check("gate_vec", vec_o, 10);
        en_i = 1'b0;
        cyc(1);
        check("en_drop_irq", irq_o, 0);
        cyc(2);

        // Overflow: set beats simultaneous clear, sticky, then clearable
        csr_i = 32'h0000_0800; tmo_clr_i = 4'b0010;
        cyc(1);
        tmo_clr_i = '0;
        check("ovf_set_wins", ovf_o, 4'b0010);
        cyc(3);
        check("ovf_sticky", ovf_o, 4'b0010);
        tmo_clr_i = 4'b0010;
        cyc(1);
        tmo_clr_i = '0;
        check("ovf_clr", ovf_o, 0);
        csr_i = '0;
        cyc(1);

        // Reset while an interrupt is pending
        en_i = 1'b1; csr_i = 32'h0015_0800;
        wait_irq("rstreq_rise");
        check("rstreq_ovf", ovf_o, 4'b0010);
        rst = 1'b1; csr_i = '0;
        cyc(1);
        check("rstreq_irq", irq_o, 0);
        check("rstreq_vec", vec_o, 0);
        check("rstreq_svc", svc_o, 0);
        check("rstreq_tmo", tmo_o, 0);
        check("rstreq_ovf", ovf_o, 0);
        rst = 1'b0;
        cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
